// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM states, header word layout
// and the default RUN-phase timeout.
package mips32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ldr_state_e;

    localparam int HDR_COUNT_MSB     = 31;
    localparam int HDR_COUNT_LSB     = 16;
    localparam int HDR_BASE_MSB      = 15;
    localparam int HDR_BASE_LSB      = 0;
    localparam int HDR_FIELD_W       = 16;
    localparam int HALT_WAIT_DEFAULT = 4095;

    function automatic logic [HDR_FIELD_W-1:0] hdrCount(input logic [31:0] word);
        return word[HDR_COUNT_MSB:HDR_COUNT_LSB];
    endfunction

    function automatic logic [HDR_FIELD_W-1:0] hdrBase(input logic [31:0] word);
        return word[HDR_BASE_MSB:HDR_BASE_LSB];
    endfunction

endpackage

// File: rtl/mips32_ldr_timeout.sv
// Counts cycles spent in RUN; expired_o flags the cycle in which the HALT_WAIT-th
// RUN edge is about to occur. The count restarts whenever run_i drops.
module mips32_ldr_timeout
    import mips32_pkg::*;
#(
    parameter int HALT_WAIT = HALT_WAIT_DEFAULT
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int               CNT_W = (HALT_WAIT > 1) ? $clog2(HALT_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALT_WAIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_o = run_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (!run_i) begin
            count_d = '0;
        end else if (!expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Streams a header plus N program words into MIPS32 memory, pulses cpu_start and waits
// for HALTED. Define MIPS32_LOADER_CHECKSUM_EN to require a trailing checksum word.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int HALT_WAIT = HALT_WAIT_DEFAULT
)(
    input  logic              clk1,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_start,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ldr_state_e             state_q, state_d;
    logic [HDR_FIELD_W-1:0] count_q, count_d;
    logic [HDR_FIELD_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [ADDR_W-1:0]      memAddr_q, memAddr_d;
    logic [31:0]            memWdata_q, memWdata_d;
    logic                   memWe_q, memWe_d;
    logic                   cpuStart_q, cpuStart_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   transfer;
    logic                   runActive;
    logic                   runExpired;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [31:0]            sum_q, sum_d;
`endif

    assign runActive = (state_q == ST_RUN);

    mips32_ldr_timeout #(
        .HALT_WAIT (HALT_WAIT)
    ) u_timeout (
        .clk_i     (clk1),
        .rst_i     (rst),
        .run_i     (runActive),
        .expired_o (runExpired)
    );

    assign s_ready   = (state_q == ST_IDLE) || (state_q == ST_HDR) || (state_q == ST_DATA);
    assign transfer  = s_valid && s_ready;
    assign busy      = (state_q != ST_IDLE);
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign cpu_start = cpuStart_q;
    assign done      = done_q;
    assign err       = err_q;

    // Memory and start outputs are registered so each lands exactly one cycle after
    // the decision that produced it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        base_d     = base_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWe_d    = 1'b0;
        cpuStart_d = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            // HDR is never entered; it decodes like IDLE so the encoding stays harmless.
            ST_IDLE, ST_HDR: begin
                if (transfer) begin
                    count_d = hdrCount(s_data);
                    base_d  = ADDR_W'(hdrBase(s_data));
                    idx_d   = '0;
                    done_d  = 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    sum_d   = s_data;
`endif
                    if (hdrCount(s_data) == '0) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (transfer) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    if (idx_q == count_q) begin
                        if (s_data == sum_q) begin
                            state_d = ST_START;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        memWe_d    = 1'b1;
                        memAddr_d  = base_q + ADDR_W'(idx_q);
                        memWdata_d = s_data;
                        idx_d      = idx_q + 16'd1;
                        sum_d      = sum_q + s_data;
                    end
`else
                    memWe_d    = 1'b1;
                    memAddr_d  = base_q + ADDR_W'(idx_q);
                    memWdata_d = s_data;
                    idx_d      = idx_q + 16'd1;
                    if (idx_d == count_q) begin
                        state_d = ST_START;
                    end
`endif
                end
            end

            ST_START: begin
                cpuStart_d = 1'b1;
                state_d    = ST_RUN;
            end

            ST_RUN: begin
                if (cpu_halted) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (runExpired) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            cpuStart_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            cpuStart_q <= cpuStart_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: directed loads checked every cycle against a
// transaction-level loader model; follows MIPS32_LOADER_CHECKSUM_EN when defined.
module tb_mips32_prog_loader;

    localparam int ADDR_W    = 10;
    localparam int HALT_WAIT = 64;
    localparam int AMOD      = 1 << ADDR_W;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_START = 2;
    localparam int P_RUN   = 3;
    localparam int P_DONE  = 4;
    localparam int P_ERR   = 5;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_start;
    logic              cpu_halted;
    logic              busy;
    logic              done;
    logic              err;

    mips32_prog_loader #(
        .ADDR_W    (ADDR_W),
        .HALT_WAIT (HALT_WAIT)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_start  (cpu_start),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk1 = ~clk1;

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Loader model: tracks where the transaction stands and what each output must be
    // in the cycle after every clock edge.
    int                phase = P_IDLE;
    int                wordsTotal = 0;
    int                wordsSeen = 0;
    int                baseAddr = 0;
    int                runCycles = 0;
    logic [31:0]       runSum = '0;
    logic              expReady = 1'b1;
    logic              expBusy = 1'b0;
    logic              expDone = 1'b0;
    logic              expErr = 1'b0;
    logic              expWe = 1'b0;
    logic              expStart = 1'b0;
    logic [ADDR_W-1:0] expAddr = '0;
    logic [31:0]       expData = '0;
    bit                checkAddr = 1'b0;

    always @(posedge clk1) begin : model
        bit take;
        take      = s_valid && (phase == P_IDLE || phase == P_LOAD);
        expWe     = 1'b0;
        expStart  = 1'b0;
        checkAddr = 1'b0;
        if (rst) begin
            phase     = P_IDLE;
            expDone   = 1'b0;
            expErr    = 1'b0;
            expAddr   = '0;
            expData   = '0;
            checkAddr = 1'b1;
        end else begin
            case (phase)
                P_IDLE: if (take) begin
                    wordsTotal = int'(s_data[31:16]);
                    baseAddr   = int'(s_data[15:0]);
                    wordsSeen  = 0;
                    runSum     = s_data;
                    expDone    = 1'b0;
                    if (wordsTotal == 0) begin
                        phase  = P_ERR;
                        expErr = 1'b1;
                    end else begin
                        phase = P_LOAD;
                    end
                end
                P_LOAD: if (take) begin
                    if (wordsSeen < wordsTotal) begin
                        expWe     = 1'b1;
                        expAddr   = ADDR_W'((baseAddr + wordsSeen) % AMOD);
                        expData   = s_data;
                        checkAddr = 1'b1;
                        wordsSeen++;
                        runSum = runSum + s_data;
                        if (wordsSeen == wordsTotal && !CSUM_EN) phase = P_START;
                    end else if (s_data == runSum) begin
                        phase = P_START;
                    end else begin
                        phase  = P_ERR;
                        expErr = 1'b1;
                    end
                end
                P_START: begin
                    expStart  = 1'b1;
                    phase     = P_RUN;
                    runCycles = 0;
                end
                P_RUN: begin
                    runCycles++;
                    if (cpu_halted) begin
                        phase   = P_DONE;
                        expDone = 1'b1;
                    end else if (runCycles == HALT_WAIT) begin
                        phase  = P_ERR;
                        expErr = 1'b1;
                    end
                end
                P_DONE: phase = P_IDLE;
                default: ;
            endcase
        end
        expReady = (phase == P_IDLE || phase == P_LOAD);
        expBusy  = (phase != P_IDLE);
    end

    bit checkEn = 1'b0;

    always @(negedge clk1) begin : compare
        if (checkEn) begin
            checkOutput("s_ready",   32'(s_ready),   32'(expReady));
            checkOutput("busy",      32'(busy),      32'(expBusy));
            checkOutput("done",      32'(done),      32'(expDone));
            checkOutput("err",       32'(err),       32'(expErr));
            checkOutput("mem_we",    32'(mem_we),    32'(expWe));
            checkOutput("cpu_start", 32'(cpu_start), 32'(expStart));
            if (checkAddr) begin
                checkOutput("mem_addr",  32'(mem_addr), 32'(expAddr));
                checkOutput("mem_wdata", mem_wdata,     expData);
            end
        end
    end

    // Processor side: backing memory, write log and a stand-in CPU that raises HALTED
    // haltAfter cycles after cpu_start (never when haltAfter is 0).
    logic [31:0]       cpuMem [0:AMOD-1];
    logic [ADDR_W-1:0] writeAddrQ [$];
    logic [31:0]       writeDataQ [$];
    logic [31:0]       factProg [0:10] = '{
        32'h280A00C8, 32'h28020001, 32'h0E94A000, 32'h21430000,
        32'h0E94A000, 32'h14431000, 32'h2C630001, 32'h0E94A000,
        32'h3460FFFC, 32'h2542FFFE, 32'hFC000000
    };
    int cycleNo = 0;
    int startCount = 0;
    int startCycle = -1;
    int haltAfter = 0;
    int runTimer = -1;

    always @(posedge clk1) cycleNo++;

    function automatic bit programIntact();
        for (int i = 0; i < 11; i++) begin
            if (cpuMem[i] !== factProg[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] factOf(input logic [31:0] n);
        logic [31:0] r;
        r = 32'd1;
        if (n > 32'd12) return 32'd0;
        for (int k = 2; k <= int'(n); k++) r = r * 32'(k);
        return r;
    endfunction

    initial begin : cpuEnv
        cpu_halted = 1'b0;
        forever begin
            @(negedge clk1);
            if (mem_we === 1'b1) begin
                cpuMem[mem_addr] = mem_wdata;
                writeAddrQ.push_back(mem_addr);
                writeDataQ.push_back(mem_wdata);
            end
            if (cpu_start === 1'b1) begin
                startCount++;
                startCycle = cycleNo;
                cpu_halted = 1'b0;
                runTimer   = 0;
            end else if (runTimer >= 0) begin
                runTimer++;
                if (haltAfter > 0 && runTimer == haltAfter) begin
                    if (programIntact()) cpuMem[198] = factOf(cpuMem[200]);
                    cpu_halted = 1'b1;
                    runTimer   = -1;
                end
            end
            if (rst === 1'b1) runTimer = -1;
        end
    end

    logic [31:0] loadBuf [0:15];

    task automatic applyStimulus(input logic [31:0] word);
        int waited;
        waited = 0;
        @(negedge clk1);
        s_valid = 1'b1;
        s_data  = word;
        while (s_ready !== 1'b1 && waited < 20) begin
            @(negedge clk1);
            waited++;
        end
        if (s_ready !== 1'b1) checkOutput("accept_wait", 32'(s_ready), 32'd1);
        @(posedge clk1);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic sendLoad(input logic [31:0] hdr, input int n, input bit corrupt);
        logic [31:0] sum;
        sum = hdr;
        applyStimulus(hdr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(loadBuf[i]);
            sum = sum + loadBuf[i];
        end
        if (CSUM_EN) applyStimulus(corrupt ? sum + 32'd1 : sum);
    endtask

    task automatic doReset();
        @(negedge clk1);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < limit) begin
            @(negedge clk1);
            waited++;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int w0;
        int s0;
        int waited;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge clk1);
        checkEn = 1'b1;
        checkOutput("rst_s_ready",   32'(s_ready),   32'd1);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_done",      32'(done),      32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
        checkOutput("rst_mem_addr",  32'(mem_addr),  32'd0);
        checkOutput("rst_mem_wdata", mem_wdata,      32'd0);
        checkOutput("rst_cpu_start", 32'(cpu_start), 32'd0);
        rst = 1'b0;

        $display("[TB] single word at 200");
        w0 = writeAddrQ.size(); s0 = startCount; haltAfter = 3;
        loadBuf[0] = 32'd7;
        sendLoad(32'h000100C8, 1, 1'b0);
        waitDone("single_done", 80);
        checkOutput("single_count", 32'(writeAddrQ.size() - w0), 32'd1);
        checkOutput("single_addr",  32'(writeAddrQ[w0]), 32'd200);
        checkOutput("single_data",  writeDataQ[w0], 32'd7);
        checkOutput("single_start", 32'(startCount - s0), 32'd1);

        $display("[TB] factorial program");
        w0 = writeAddrQ.size(); s0 = startCount; haltAfter = 40;
        for (int i = 0; i < 11; i++) loadBuf[i] = factProg[i];
        sendLoad(32'h000B0000, 11, 1'b0);
        waitDone("fact_done", 150);
        checkOutput("fact_count", 32'(writeAddrQ.size() - w0), 32'd11);
        for (int i = 0; i < 11; i++) begin
            checkOutput("fact_addr", 32'(writeAddrQ[w0 + i]), 32'(i));
            checkOutput("fact_data", writeDataQ[w0 + i], factProg[i]);
        end
        checkOutput("fact_start",  32'(startCount - s0), 32'd1);
        checkOutput("fact_result", cpuMem[198], 32'd5040);

        $display("[TB] address wrap");
        w0 = writeAddrQ.size(); haltAfter = 2;
        loadBuf[0] = 32'hAAAA0001;
        loadBuf[1] = 32'hBBBB0002;
        sendLoad(32'h000203FF, 2, 1'b0);
        waitDone("wrap_done", 80);
        checkOutput("wrap_count", 32'(writeAddrQ.size() - w0), 32'd2);
        checkOutput("wrap_addr0", 32'(writeAddrQ[w0]), 32'd1023);
        checkOutput("wrap_addr1", 32'(writeAddrQ[w0 + 1]), 32'd0);
        checkOutput("wrap_data1", writeDataQ[w0 + 1], 32'hBBBB0002);

        $display("[TB] reset in the middle of data");
        w0 = writeAddrQ.size(); s0 = startCount;
        applyStimulus(32'h0005012C);
        applyStimulus(32'h11111111);
        applyStimulus(32'h22222222);
        doReset();
        checkOutput("midrst_busy",    32'(busy),     32'd0);
        checkOutput("midrst_ready",   32'(s_ready),  32'd1);
        checkOutput("midrst_addr",    32'(mem_addr), 32'd0);
        repeat (6) @(negedge clk1);
        checkOutput("midrst_count",   32'(writeAddrQ.size() - w0), 32'd2);
        checkOutput("midrst_start",   32'(startCount - s0), 32'd0);
        checkOutput("midrst_kept",    cpuMem[301], 32'h22222222);

        $display("[TB] halt never arrives");
        haltAfter = 0;
        loadBuf[0] = 32'h12345678;
        sendLoad(32'h00010100, 1, 1'b0);
        waited = 0;
        while (err !== 1'b1 && waited < HALT_WAIT + 20) begin
            @(negedge clk1);
            waited++;
        end
        checkOutput("timeout_err",     32'(err), 32'd1);
        checkOutput("timeout_latency", 32'(cycleNo - startCycle), 32'd64);
        doReset();
        checkOutput("timeout_cleared", 32'(err), 32'd0);

        $display("[TB] zero-length header");
        w0 = writeAddrQ.size();
        applyStimulus(32'h00000000);
        @(negedge clk1);
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        repeat (4) @(negedge clk1);
        s_valid = 1'b0;
        checkOutput("zero_err",   32'(err),     32'd1);
        checkOutput("zero_ready", 32'(s_ready), 32'd0);
        checkOutput("zero_busy",  32'(busy),    32'd1);
        checkOutput("zero_count", 32'(writeAddrQ.size() - w0), 32'd0);
        doReset();
        checkOutput("zero_cleared", 32'(err), 32'd0);

`ifdef MIPS32_LOADER_CHECKSUM_EN
        $display("[TB] wrong checksum");
        w0 = writeAddrQ.size(); s0 = startCount;
        loadBuf[0] = 32'h00000005;
        loadBuf[1] = 32'h00000006;
        sendLoad(32'h00020010, 2, 1'b1);
        repeat (4) @(negedge clk1);
        checkOutput("csum_err",   32'(err), 32'd1);
        checkOutput("csum_start", 32'(startCount - s0), 32'd0);
        checkOutput("csum_count", 32'(writeAddrQ.size() - w0), 32'd2);
        doReset();
`endif

        repeat (2) @(negedge clk1);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the memory word-address width.
REQ-002 SHALL have parameter HALT_WAIT, default 4095, meaning the maximum cycles to wait for cpu_halted after cpu_start.
REQ-003 SHALL have port clk1 (in, 1), the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst (in, 1), the reset: synchronous and active-high.
REQ-005 SHALL have port s_valid (in, 1), meaning the upstream word is valid.
REQ-006 SHALL have port s_data (in, 32), the upstream word.
REQ-007 SHALL have port s_ready (out, 1), meaning the loader accepts a word this cycle.
REQ-008 SHALL have port mem_we (out, 1), the write strobe to processor memory.
REQ-009 SHALL have port mem_addr (out, ADDR_W), the memory word address.
REQ-010 SHALL have port mem_wdata (out, 32), the memory write data.
REQ-011 SHALL have port cpu_start (out, 1), a one-cycle pulse that releases the processor (PC=0, HALTED=0, TAKEN_BRANCH=0).
REQ-012 SHALL have port cpu_halted (in, 1), the processor HALTED flag.
REQ-013 SHALL have port busy (out, 1), meaning the loader is not in IDLE.
REQ-014 SHALL have port done (out, 1), meaning the run completed; sticky until the next header.
REQ-015 SHALL have port err (out, 1), meaning a protocol/timeout error; sticky until rst.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA, START, RUN, DONE, ERR.
REQ-017 SHALL set s_ready high only in IDLE, HDR and DATA; a transfer occurs when s_valid && s_ready.
REQ-018 SHALL, on an IDLE transfer, treat the word as the header: [31:16] is count N, [15:0] is base address (truncated to ADDR_W); on an IDLE transfer, go to DATA and clear done.
REQ-019 SHALL, when header N==0, go to ERR with no memory write.
REQ-020 SHALL, for each DATA transfer, drive mem_we=1, mem_addr=base+i (mod 2^ADDR_W, wraps silently) and mem_wdata=word exactly one cycle after acceptance; i counts 0..N-1.
REQ-021 SHALL keep mem_we low in every cycle not following a DATA transfer; s_valid gaps insert idle cycles without error.
REQ-022 SHALL, after the N-th data transfer, enter START; cpu_start SHALL be high for exactly one cycle, the cycle after the last mem_we.
REQ-023 SHALL, in RUN, count cycles; on cpu_halted==1 go to DONE, raising done the next cycle; on the count reaching HALT_WAIT, go to ERR.
REQ-024 SHALL ignore cpu_halted in every state except RUN.
REQ-025 SHALL return from DONE to IDLE after one cycle; done stays high.
REQ-026 SHALL hold ERR (s_ready=0, busy=1) until rst.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, in any state including mid-DATA, enter IDLE with s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, busy=0, done=0, err=0 and counters cleared.
REQ-028 SHALL leave words already written in memory untouched on reset.

Configuration
REQ-029 SHALL, with macro MIPS32_LOADER_CHECKSUM_EN defined, accept one extra word after the N data words, equal to the mod-2^32 sum of header and data words; on match, go to START, otherwise to ERR with no cpu_start.
REQ-030 SHALL, without MIPS32_LOADER_CHECKSUM_EN, accept no checksum word and go to START directly after data.

Structure
REQ-031 SHALL place the state enum, header field positions and the HALT_WAIT default in shared package mips32_pkg.
REQ-032 SHALL use one sub-module, mips32_ldr_timeout (RUN-state cycle counter with expiry flag).

Verification
REQ-033 SHALL cover: header 0x000B0000 followed by the 11 factorial program words -> 11 mem_we pulses at addresses 0..10, then one cpu_start; model asserts HALTED at cycle 40 -> done=1, mem[198]=5040.
REQ-034 SHALL cover: header 0x000100C8 followed by data 7 -> single write addr 200 data 7.
REQ-035 SHALL cover: header 0x000203FF followed by words A, B -> writes at addr 1023 then 0 (wrap).
REQ-036 SHALL cover: header 0x00000000 -> err=1, no mem_we, s_ready=0 until rst.
REQ-037 SHALL cover: rst asserted after 2 of 5 data words -> next cycle IDLE, busy=0, no further writes, no cpu_start.
REQ-038 SHALL cover: cpu_halted never set -> err=1 exactly HALT_WAIT cycles after cpu_start; with MIPS32_LOADER_CHECKSUM_EN, a wrong checksum -> err=1 and no cpu_start.
